// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared constants for the MIPS pipeline slice: decode ALUOP codes, primary
//   opcode / funct values, the link register index, instruction field widths
//   and a small byte-lane helper used by the write-back formatter.
// -----------------------------------------------------------------------------
package mips_pkg;

    // Datapath geometry
    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int INSN_W   = 32;
    localparam int ALUOP_W  = 6;
    localparam int IMM_W    = 16;
    localparam int OPC_W    = 6;
    localparam int FUNCT_W  = 6;

    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    // ALUOP codes produced by decode
    localparam logic [ALUOP_W-1:0] ADD_OP   = 6'd0;
    localparam logic [ALUOP_W-1:0] ADDU_OP  = 6'd1;
    localparam logic [ALUOP_W-1:0] SUB_OP   = 6'd2;
    localparam logic [ALUOP_W-1:0] SUBU_OP  = 6'd3;
    localparam logic [ALUOP_W-1:0] AND_OP   = 6'd4;
    localparam logic [ALUOP_W-1:0] OR_OP    = 6'd5;
    localparam logic [ALUOP_W-1:0] XOR_OP   = 6'd6;
    localparam logic [ALUOP_W-1:0] NOR_OP   = 6'd7;
    localparam logic [ALUOP_W-1:0] SLT_OP   = 6'd8;
    localparam logic [ALUOP_W-1:0] SLTU_OP  = 6'd9;
    localparam logic [ALUOP_W-1:0] SLL_OP   = 6'd10;
    localparam logic [ALUOP_W-1:0] SRL_OP   = 6'd11;
    localparam logic [ALUOP_W-1:0] SRA_OP   = 6'd12;
    localparam logic [ALUOP_W-1:0] ADDI_OP  = 6'd13;
    localparam logic [ALUOP_W-1:0] LUI_OP   = 6'd14;
    localparam logic [ALUOP_W-1:0] LB_OP    = 6'd15;
    localparam logic [ALUOP_W-1:0] LBU_OP   = 6'd16;
    localparam logic [ALUOP_W-1:0] LW_OP    = 6'd17;
    localparam logic [ALUOP_W-1:0] SW_OP    = 6'd18;
    localparam logic [ALUOP_W-1:0] BEQ_OP   = 6'd19;
    localparam logic [ALUOP_W-1:0] BNE_OP   = 6'd20;
    localparam logic [ALUOP_W-1:0] J_OP     = 6'd21;
    localparam logic [ALUOP_W-1:0] JAL_OP   = 6'd22;
    localparam logic [ALUOP_W-1:0] JR_OP    = 6'd23;
    localparam logic [ALUOP_W-1:0] JALR_OP  = 6'd24;
    localparam logic [ALUOP_W-1:0] MULT_OP  = 6'd25;
    localparam logic [ALUOP_W-1:0] DIV_OP   = 6'd26;
    localparam logic [ALUOP_W-1:0] MFHI_OP  = 6'd27;
    localparam logic [ALUOP_W-1:0] MFLO_OP  = 6'd28;
    localparam logic [ALUOP_W-1:0] NOP_OP   = 6'd29;

    // Primary opcodes
    localparam logic [OPC_W-1:0] OPC_SPECIAL = 6'h00;
    localparam logic [OPC_W-1:0] OPC_JAL     = 6'h03;
    localparam logic [OPC_W-1:0] OPC_ADDI    = 6'h08;
    localparam logic [OPC_W-1:0] OPC_LUI     = 6'h0F;
    localparam logic [OPC_W-1:0] OPC_LB      = 6'h20;
    localparam logic [OPC_W-1:0] OPC_LBU     = 6'h24;

    // SPECIAL funct codes
    localparam logic [FUNCT_W-1:0] FN_JALR = 6'h09;
    localparam logic [FUNCT_W-1:0] FN_MFHI = 6'h10;
    localparam logic [FUNCT_W-1:0] FN_MFLO = 6'h12;
    localparam logic [FUNCT_W-1:0] FN_MULT = 6'h18;
    localparam logic [FUNCT_W-1:0] FN_DIV  = 6'h1A;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;

    // Select byte lane sel of a 32-bit word (lane 0 = bits [7:0]).
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wb_format.sv
// -----------------------------------------------------------------------------
// wb_format
//   Combinational write-back formatter: turns one queued instruction into a
//   regfile write (enable, index, data).
//   Inputs : insn_i, pc_i, aluop_i, rdst_i, rwd_i, rwe_i, aluout_i, dmout_i,
//            hi_i/lo_i (current HI/LO registers)
//   Outputs: we_o (write enable), d_o (dest index), data_o (write data)
// -----------------------------------------------------------------------------
module wb_format
    import mips_pkg::*;
#(
    parameter int DATA_W_P = 32,
    parameter int REG_W_P  = 5
) (
    input  logic [31:0]         insn_i,
    input  logic [DATA_W_P-1:0] pc_i,
    input  logic [5:0]          aluop_i,
    input  logic                rdst_i,
    input  logic                rwd_i,
    input  logic                rwe_i,
    input  logic [DATA_W_P-1:0] aluout_i,
    input  logic [DATA_W_P-1:0] dmout_i,
    input  logic [DATA_W_P-1:0] hi_i,
    input  logic [DATA_W_P-1:0] lo_i,
    output logic                we_o,
    output logic [REG_W_P-1:0]  d_o,
    output logic [DATA_W_P-1:0] data_o
);

    logic       we_raw_s;
    logic [7:0] lane_s;
    logic       unused_insn_s;

    // Opcode/funct bits are already folded into aluop by decode.
    assign unused_insn_s = ^insn_i[31:21];
    assign lane_s        = byte_lane(dmout_i[31:0], aluout_i[1:0]);

    // Destination index: JAL always links into r31.
    always_comb begin
        if (aluop_i == JAL_OP) begin
            d_o = LINK_REG;
        end else if (rdst_i) begin
            d_o = insn_i[15:11];
        end else begin
            d_o = insn_i[20:16];
        end
    end

    // Write enable override by aluop; r0 is never written.
    always_comb begin
        case (aluop_i)
            JAL_OP, JALR_OP, MFHI_OP, MFLO_OP: we_raw_s = 1'b1;
            NOP_OP, MULT_OP, DIV_OP:           we_raw_s = 1'b0;
            default:                           we_raw_s = rwe_i;
        endcase
        we_o = we_raw_s && (d_o != 5'd0);
    end

    // Write data selection, first match wins.
    always_comb begin
        case (aluop_i)
            JAL_OP, JALR_OP: data_o = pc_i + 32'd8;
            MFHI_OP:         data_o = hi_i;
            MFLO_OP:         data_o = lo_i;
            LUI_OP:          data_o = {insn_i[15:0], 16'h0000};
            LB_OP:           data_o = {{(DATA_W_P-8){lane_s[7]}}, lane_s};
            LBU_OP:          data_o = {{(DATA_W_P-8){1'b0}}, lane_s};
            default:         data_o = rwd_i ? dmout_i : aluout_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Write-back end of the pipeline. Completed instructions enter a DEPTH-entry
//   in-order queue over valid/ready; the head entry is formatted and issued as
//   at most one regfile write per cycle. Owns the HI/LO registers, which are
//   updated when a MULT/DIV entry leaves the queue.
//   Ports: clock, reset_n (async active-low), in_valid/in_ready handshake,
//          in_* instruction payload, rf_hold (regfile busy), rwe/d/rd write.
//   Build option WB_FWD_EN: adds fwd_valid/fwd_d/fwd_data, the write formed
//   by the youngest queued entry (all zero when it does not write).
// -----------------------------------------------------------------------------
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_insn,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [5:0]        in_aluop,
    input  logic              in_rdst,
    input  logic              in_rwd,
    input  logic              in_rwe,
    input  logic [DATA_W-1:0] in_aluout,
    input  logic [DATA_W-1:0] in_dmout,
    input  logic [DATA_W-1:0] in_hi,
    input  logic [DATA_W-1:0] in_lo,
    input  logic              rf_hold,
`ifdef WB_FWD_EN
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_d,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              rwe,
    output logic [REG_W-1:0]  d,
    output logic [DATA_W-1:0] rd
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]       insn;
        logic [DATA_W-1:0] pc;
        logic [5:0]        aluop;
        logic              rdst;
        logic              rwd;
        logic              rwe;
        logic [DATA_W-1:0] aluout;
        logic [DATA_W-1:0] dmout;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              push_s, pop_s;
    entry_t            head_s, in_entry_s;
    logic              fmt_we_s;
    logic [REG_W-1:0]  fmt_d_s;
    logic [DATA_W-1:0] fmt_data_s;

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push_s   = in_valid && in_ready;
    // The head leaves whenever the regfile port is free, writing or not.
    assign pop_s    = (count_q != CNT_W'(0)) && !rf_hold;
    assign head_s   = mem_q[head_q];

    assign in_entry_s = '{insn: in_insn, pc: in_pc, aluop: in_aluop, rdst: in_rdst,
                          rwd: in_rwd, rwe: in_rwe, aluout: in_aluout,
                          dmout: in_dmout, hi: in_hi, lo: in_lo};

    // Queue pointer and occupancy next-state; pointers wrap modulo DEPTH.
    always_comb begin
        head_d = pop_s  ? head_q + PTR_W'(1) : head_q;
        tail_d = push_s ? tail_q + PTR_W'(1) : tail_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // HI/LO follow a MULT/DIV as it retires from the head.
    always_comb begin
        if (pop_s && ((head_s.aluop == MULT_OP) || (head_s.aluop == DIV_OP))) begin
            hi_d = head_s.hi;
            lo_d = head_s.lo;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // Queue control and HI/LO state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Queue payload storage, written at the tail on push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[tail_q] <= in_entry_s;
        end else begin
            mem_q[tail_q] <= mem_q[tail_q];
        end
    end

    wb_format #(.DATA_W_P(DATA_W), .REG_W_P(REG_W)) u_fmt_head (
        .insn_i   (head_s.insn),
        .pc_i     (head_s.pc),
        .aluop_i  (head_s.aluop),
        .rdst_i   (head_s.rdst),
        .rwd_i    (head_s.rwd),
        .rwe_i    (head_s.rwe),
        .aluout_i (head_s.aluout),
        .dmout_i  (head_s.dmout),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .we_o     (fmt_we_s),
        .d_o      (fmt_d_s),
        .data_o   (fmt_data_s)
    );

    // Regfile write port: silent while empty or held.
    always_comb begin
        if (pop_s) begin
            rwe = fmt_we_s;
            d   = fmt_d_s;
            rd  = fmt_data_s;
        end else begin
            rwe = 1'b0;
            d   = '0;
            rd  = '0;
        end
    end

`ifdef WB_FWD_EN
    entry_t            young_s;
    logic              young_we_s;
    logic [REG_W-1:0]  young_d_s;
    logic [DATA_W-1:0] young_data_s;

    // Youngest entry sits one slot behind the tail.
    assign young_s = mem_q[tail_q - PTR_W'(1)];

    wb_format #(.DATA_W_P(DATA_W), .REG_W_P(REG_W)) u_fmt_young (
        .insn_i   (young_s.insn),
        .pc_i     (young_s.pc),
        .aluop_i  (young_s.aluop),
        .rdst_i   (young_s.rdst),
        .rwd_i    (young_s.rwd),
        .rwe_i    (young_s.rwe),
        .aluout_i (young_s.aluout),
        .dmout_i  (young_s.dmout),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .we_o     (young_we_s),
        .d_o      (young_d_s),
        .data_o   (young_data_s)
    );

    // Forwarding view of the youngest queued write.
    always_comb begin
        if ((count_q != CNT_W'(0)) && young_we_s) begin
            fwd_valid = 1'b1;
            fwd_d     = young_d_s;
            fwd_data  = young_data_s;
        end else begin
            fwd_valid = 1'b0;
            fwd_d     = '0;
            fwd_data  = '0;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//   Randomized + directed bench. Accepted instructions are turned into the
//   expected regfile write by a reference model (program-order HI/LO) and
//   pushed into a scoreboard; a monitor pops and compares on every rwe.
// -----------------------------------------------------------------------------
module tb_writeback_stage;
    import mips_pkg::*;

    localparam int TB_DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_insn = 32'd0, in_pc = 32'd0, in_aluout = 32'd0, in_dmout = 32'd0;
    logic [31:0] in_hi = 32'd0, in_lo = 32'd0;
    logic [5:0]  in_aluop = 6'd0;
    logic        in_rdst = 1'b0, in_rwd = 1'b0, in_rwe = 1'b0, rf_hold = 1'b0;
    logic        rwe;
    logic [4:0]  d;
    logic [31:0] rd;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_d;
    logic [31:0] fwd_data;
`endif

    writeback_stage #(.DEPTH(TB_DEPTH), .DATA_W(32), .REG_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .in_aluop(in_aluop), .in_rdst(in_rdst),
        .in_rwd(in_rwd), .in_rwe(in_rwe), .in_aluout(in_aluout), .in_dmout(in_dmout),
        .in_hi(in_hi), .in_lo(in_lo), .rf_hold(rf_hold),
`ifdef WB_FWD_EN
        .fwd_valid(fwd_valid), .fwd_d(fwd_d), .fwd_data(fwd_data),
`endif
        .rwe(rwe), .d(d), .rd(rd)
    );

    always #5 clock = ~clock;

    typedef struct { logic [4:0] d; logic [31:0] data; } wr_t;
    wr_t sb[$];

    int          checks = 0;
    int          failures = 0;
    int          mcount = 0;
    logic [31:0] mhi = 32'd0, mlo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: the write an instruction must produce, from the ISA rules.
    task automatic ref_model(output bit w, output logic [4:0] dd, output logic [31:0] data);
        logic [7:0] b;
        b = 8'((in_dmout >> (8 * int'(in_aluout[1:0]))) & 32'hFF);
        if (in_aluop == JAL_OP) dd = 5'd31;
        else dd = in_rdst ? in_insn[15:11] : in_insn[20:16];
        if (in_aluop inside {JAL_OP, JALR_OP, MFHI_OP, MFLO_OP}) w = 1'b1;
        else if (in_aluop inside {NOP_OP, MULT_OP, DIV_OP}) w = 1'b0;
        else w = in_rwe;
        if (dd == 5'd0) w = 1'b0;
        if (in_aluop inside {JAL_OP, JALR_OP}) data = in_pc + 32'd8;
        else if (in_aluop == MFHI_OP) data = mhi;
        else if (in_aluop == MFLO_OP) data = mlo;
        else if (in_aluop == LUI_OP) data = {in_insn[15:0], 16'h0000};
        else if (in_aluop == LB_OP) data = 32'($signed(b));
        else if (in_aluop == LBU_OP) data = {24'h0, b};
        else data = in_rwd ? in_dmout : in_aluout;
        // In-order retirement: HI/LO change at this point in program order.
        if (in_aluop inside {MULT_OP, DIV_OP}) begin
            mhi = in_hi;
            mlo = in_lo;
        end
    endtask

    // One clock: check ready before the edge, update the model at the edge.
    task automatic step();
        bit acc, pop, w;
        wr_t e;
        @(negedge clock);
        check("in_ready", 32'(in_ready), 32'(mcount < TB_DEPTH));
        @(posedge clock);
        acc = in_valid && (mcount < TB_DEPTH);
        pop = (mcount > 0) && !rf_hold;
        if (acc) begin
            ref_model(w, e.d, e.data);
            if (w) sb.push_back(e);
        end
        mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
        #1;
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [31:0] insn,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dm,
                         input bit rdst, input bit rwdv, input bit rwev, input bit hold);
        in_valid = v; in_aluop = op; in_insn = insn; in_pc = pc;
        in_aluout = alu; in_dmout = dm; in_rdst = rdst; in_rwd = rwdv;
        in_rwe = rwev; rf_hold = hold;
        step();
    endtask

    task automatic expect_out(input string name, input bit er, input logic [4:0] ed, input logic [31:0] edata);
        check({name, ".rwe"}, 32'(rwe), 32'(er));
        if (er) begin
            check({name, ".d"}, 32'(d), 32'(ed));
            check({name, ".rd"}, rd, edata);
        end
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clock);
            if (rwe) begin
                check("write_while_hold", 32'(rf_hold), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got d=%0d rd=0x%08h, expected no write", d, rd);
                end else begin
                    e = sb.pop_front();
                    check("sb.d", 32'(d), 32'(e.d));
                    check("sb.rd", rd, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [5:0] ops [31];

    initial begin
        // Reset state
        #2;
        expect_out("reset", 1'b0, 5'd0, 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // 1: ADDU to r5, written the cycle after acceptance
        drive(1, ADDU_OP, 32'(5) << 11, 32'h100, 32'h1234, 32'h0, 1, 0, 1, 0);
        expect_out("addu", 1'b1, 5'd5, 32'h1234);
        // 2: LB / LBU lane 2 of 0x0080FF11
        drive(1, LB_OP, 32'(7) << 16, 32'h104, 32'h1002, 32'h0080FF11, 0, 1, 1, 0);
        expect_out("lb", 1'b1, 5'd7, 32'hFFFFFF80);
        drive(1, LBU_OP, 32'(7) << 16, 32'h108, 32'h1002, 32'h0080FF11, 0, 1, 1, 0);
        expect_out("lbu", 1'b1, 5'd7, 32'h00000080);
        // 3: JAL links pc+8 into r31 regardless of in_rwe
        drive(1, JAL_OP, 32'h0C000000, 32'h400, 32'h0, 32'h0, 0, 0, 0, 0);
        expect_out("jal", 1'b1, 5'd31, 32'h408);
        // 4: MULT then MFHI sees the new HI; r0 is never written
        in_hi = 32'd7; in_lo = 32'd9;
        drive(1, MULT_OP, 32'h0, 32'h40C, 32'h0, 32'h0, 0, 0, 1, 0);
        expect_out("mult", 1'b0, 5'd0, 32'd0);
        drive(1, MFHI_OP, 32'(3) << 11, 32'h410, 32'h0, 32'h0, 1, 0, 0, 0);
        expect_out("mfhi", 1'b1, 5'd3, 32'd7);
        drive(1, ADDI_OP, 32'h20000055, 32'h414, 32'h55, 32'h0, 0, 0, 1, 0);
        expect_out("addi_r0", 1'b0, 5'd0, 32'd0);
        drive(0, NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);

        // 5: hold for three pushes; the third is refused, then two drain in order
        drive(1, ADDU_OP, 32'(1) << 11, 32'h500, 32'hA1, 32'h0, 1, 0, 1, 1);
        drive(1, ADDU_OP, 32'(2) << 11, 32'h504, 32'hB2, 32'h0, 1, 0, 1, 1);
        check("full.in_ready", 32'(in_ready), 32'd0);
        drive(1, ADDU_OP, 32'(3) << 11, 32'h508, 32'hC3, 32'h0, 1, 0, 1, 1);
        drive(0, NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        expect_out("drain2", 1'b1, 5'd2, 32'hB2);
        drive(0, NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        check("drained.sb", 32'(sb.size()), 32'd0);

        // 6: reset with two entries queued discards them and clears HI/LO
        drive(1, ADDU_OP, 32'(4) << 11, 32'h600, 32'hD4, 32'h0, 1, 0, 1, 1);
        drive(1, ADDU_OP, 32'(6) << 11, 32'h604, 32'hE5, 32'h0, 1, 0, 1, 1);
        in_valid = 1'b0; rf_hold = 1'b0; reset_n = 1'b0;
        #1;
        expect_out("rst_mid", 1'b0, 5'd0, 32'd0);
        check("rst_mid.in_ready", 32'(in_ready), 32'd1);
        sb.delete(); mcount = 0; mhi = 32'd0; mlo = 32'd0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(0, NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        drive(1, MFHI_OP, 32'(4) << 11, 32'h700, 32'h0, 32'h0, 1, 0, 1, 0);
        expect_out("rst_hi", 1'b1, 5'd4, 32'd0);
        drive(1, MFLO_OP, 32'(5) << 11, 32'h704, 32'h0, 32'h0, 1, 0, 1, 0);
        expect_out("rst_lo", 1'b1, 5'd5, 32'd0);

        // Random traffic
        ops = '{ADD_OP, ADDU_OP, SUB_OP, SUBU_OP, AND_OP, OR_OP, XOR_OP, NOR_OP,
                SLT_OP, SLTU_OP, SLL_OP, SRL_OP, SRA_OP, ADDI_OP, LUI_OP, LB_OP,
                LBU_OP, LW_OP, SW_OP, BEQ_OP, BNE_OP, J_OP, JAL_OP, JR_OP,
                JALR_OP, MULT_OP, DIV_OP, MFHI_OP, MFLO_OP, NOP_OP, 6'h3F};
        for (int i = 0; i < 400; i++) begin
            in_hi = $urandom; in_lo = $urandom;
            drive(($urandom_range(0, 9) < 7), ops[$urandom_range(0, 30)], $urandom, $urandom,
                  $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) < 3));
        end

        // Drain
        for (int i = 0; i < 10 && mcount > 0; i++)
            drive(0, NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        check("final.count", 32'(mcount), 32'd0);
        drive(0, NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        check("final.sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
